// File: rtl/crc_check_if.sv
// Codeword handshake and result bus for the CRC checker.
// The master drives a codeword plus generator polynomial; the slave returns status and the registered result.
interface crc_check_if #(
  parameter int unsigned WCODE = 4,
  parameter int unsigned WPOLY = 4
);

  logic                      i_valid;
  logic [WCODE+WPOLY-2:0]    i_code;
  logic [WPOLY-1:0]          i_poly;
  logic                      o_ready;
  logic                      o_busy;
  logic                      o_done;
  logic [WPOLY-2:0]          o_syndrome;
  logic                      o_err;
  logic [WCODE-1:0]          o_data;

  modport master (
    output i_valid,
    output i_code,
    output i_poly,
    input  o_ready,
    input  o_busy,
    input  o_done,
    input  o_syndrome,
    input  o_err,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_code,
    input  i_poly,
    output o_ready,
    output o_busy,
    output o_done,
    output o_syndrome,
    output o_err,
    output o_data
  );

endinterface

// File: rtl/crc_check.sv
// Serial CRC checker: long division of the received codeword by i_poly, one data bit per cycle.
// The remainder is the syndrome; any nonzero bit flags an error.
module crc_check #(
  parameter int unsigned WCODE = 4,
  parameter int unsigned WPOLY = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  crc_check_if.slave bus
);

  localparam int unsigned LEN  = WCODE + WPOLY - 1;
  localparam int unsigned WSYN = WPOLY - 1;
  localparam int unsigned WCNT = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LEN-1:0]    work_q,  work_d;
  logic [WPOLY-1:0]  poly_q,  poly_d;
  logic [WCNT-1:0]   cnt_q,   cnt_d;
  logic [WCODE-1:0]  hold_q,  hold_d;
  logic [WSYN-1:0]   syn_q,   syn_d;
  logic              err_q,   err_d;
  logic [WCODE-1:0]  data_q,  data_d;

  logic              accept_c;
  logic [WCNT-1:0]   tap_c;
  logic [LEN-1:0]    step_c;

  // One division step: the tested bit is the leading bit of the current window.
  always_comb begin
    tap_c  = cnt_q + WCNT'(WPOLY - 1);
    step_c = work_q;
    if (work_q[tap_c]) begin
      step_c = work_q ^ (LEN'(poly_q) << cnt_q);
    end
  end

  assign accept_c = (state_q == ST_IDLE) && bus.i_valid;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    poly_d  = poly_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    syn_d   = syn_q;
    err_d   = err_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          work_d  = bus.i_code;
          poly_d  = bus.i_poly;
          hold_d  = bus.i_code[LEN-1:WSYN];
          cnt_d   = WCNT'(WCODE - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = step_c;
        if (cnt_q == '0) begin
          syn_d   = step_c[WSYN-1:0];
          err_d   = |step_c[WSYN-1:0];
          data_d  = hold_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - WCNT'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset also clears results, so an aborted check leaves a zero syndrome.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      poly_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      poly_q  <= poly_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Status is a direct decode of the registered state; ready also drops while reset is asserted.
  assign bus.o_ready    = (state_q == ST_IDLE) && !i_rst;
  assign bus.o_busy     = (state_q == ST_SHIFT);
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_syndrome = syn_q;
  assign bus.o_err      = err_q;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check with WCODE=4, WPOLY=4; expected syndromes computed by hand.
module tb_crc_check;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  crc_check_if #(.WCODE(4), .WPOLY(4)) bus ();

  crc_check #(.WCODE(4), .WPOLY(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one codeword from an idle negedge and follow it through to the idle cycle after DONE.
  task automatic run_check(input logic [6:0] code, input logic [3:0] poly,
                           input logic [2:0] syn, input logic err, input logic [3:0] data,
                           input bit perturb);
    bus.i_valid = 1'b1;
    bus.i_code  = code;
    bus.i_poly  = poly;
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("busy",        32'(bus.o_busy),  32'd1);
      check_eq("ready_busy",  32'(bus.o_ready), 32'd0);
      check_eq("done_early",  32'(bus.o_done),  32'd0);
      if (perturb) begin
        bus.i_code  = ~code;
        bus.i_poly  = 4'b1111;
        bus.i_valid = 1'b1;
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    check_eq("done",        32'(bus.o_done),     32'd1);
    check_eq("busy_done",   32'(bus.o_busy),     32'd0);
    check_eq("syndrome",    32'(bus.o_syndrome), 32'(syn));
    check_eq("err",         32'(bus.o_err),      32'(err));
    check_eq("data",        32'(bus.o_data),     32'(data));
    @(negedge clk);
    check_eq("done_pulse",  32'(bus.o_done),     32'd0);
    check_eq("ready_idle",  32'(bus.o_ready),    32'd1);
    check_eq("syn_hold",    32'(bus.o_syndrome), 32'(syn));
    check_eq("err_hold",    32'(bus.o_err),      32'(err));
    check_eq("data_hold",   32'(bus.o_data),     32'(data));
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_code  = 7'b1101001;
    bus.i_poly  = 4'b1011;

    // Reset for two edges with i_valid high; it must be ignored.
    repeat (2) @(negedge clk);
    check_eq("rst_ready",   32'(bus.o_ready),    32'd0);
    check_eq("rst_busy",    32'(bus.o_busy),     32'd0);
    check_eq("rst_done",    32'(bus.o_done),     32'd0);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("init_ready",  32'(bus.o_ready),    32'd1);
    check_eq("init_busy",   32'(bus.o_busy),     32'd0);
    check_eq("init_done",   32'(bus.o_done),     32'd0);
    check_eq("init_syn",    32'(bus.o_syndrome), 32'd0);
    check_eq("init_err",    32'(bus.o_err),      32'd0);
    check_eq("init_data",   32'(bus.o_data),     32'd0);

    run_check(7'b1101001, 4'b1011, 3'b000, 1'b0, 4'b1101, 1'b0);
    run_check(7'b1101011, 4'b1011, 3'b010, 1'b1, 4'b1101, 1'b0);
    run_check(7'b0000101, 4'b1011, 3'b101, 1'b1, 4'b0000, 1'b1);
    run_check(7'b1110000, 4'b1011, 3'b100, 1'b1, 4'b1110, 1'b0);
    // Polynomial without its leading term still divides as written.
    run_check(7'b1000000, 4'b0011, 3'b101, 1'b1, 4'b1000, 1'b0);
    run_check(7'b0000000, 4'b1011, 3'b000, 1'b0, 4'b0000, 1'b0);

    // Continuous i_valid: acceptance every 6 cycles.
    bus.i_valid = 1'b1;
    bus.i_code  = 7'b1101001;
    bus.i_poly  = 4'b1011;
    for (int i = 0; i < 18; i++) begin
      check_eq("b2b_ready", 32'(bus.o_ready), 32'((i % 6) == 0));
      check_eq("b2b_busy",  32'(bus.o_busy),  32'(((i % 6) >= 1) && ((i % 6) <= 4)));
      check_eq("b2b_done",  32'(bus.o_done),  32'((i % 6) == 5));
      if ((i % 6) == 5) begin
        check_eq("b2b_syn",  32'(bus.o_syndrome), 32'd0);
        check_eq("b2b_data", 32'(bus.o_data),     32'hd);
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    @(negedge clk);

    // Leave a nonzero result so that the abort clearing it is visible.
    run_check(7'b0000101, 4'b1011, 3'b101, 1'b1, 4'b0000, 1'b0);

    bus.i_valid = 1'b1;
    bus.i_code  = 7'b1110000;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_busy2", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(bus.o_ready),    32'd0);
    check_eq("abort_busy",  32'(bus.o_busy),     32'd0);
    check_eq("abort_syn",   32'(bus.o_syndrome), 32'd0);
    check_eq("abort_err",   32'(bus.o_err),      32'd0);
    check_eq("abort_data",  32'(bus.o_data),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_ready",   32'(bus.o_ready),    32'd1);
    for (int i = 0; i < 6; i++) begin
      check_eq("abort_nodone", 32'(bus.o_done),  32'd0);
      check_eq("abort_idle",   32'(bus.o_ready), 32'd1);
      @(negedge clk);
    end
    check_eq("abort_syn_end", 32'(bus.o_syndrome), 32'd0);
    check_eq("abort_err_end", 32'(bus.o_err),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
